ras_ctrl: RTL

Front/back-end driver for the return address stack in IF/branch.
- Predecodes fetched MIPS instructions to issue RAS push/pop requests.
- Tracks in-flight predicted return targets in a FIFO, checks them against execute-stage resolution, and drives the RAS correction bus and flush.
- Sits between the fetch stage, the RAS, and the EX branch-resolve path.

---
 rtl/ras_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ras_ctrl.sv
// ras_ctrl: fetch-side predecode and RAS request generation, in-flight
// return-target tracking, and EX-stage return verification driving the RAS
// correction bus and the front-end flush.
// Optional build macro RAS_CTRL_STAT_EN adds saturating counters for return
// checks and return mispredicts (stat_ret_o / stat_miss_o).
module ras_ctrl #(
  parameter int DEPTH   = 8,  // in-flight return-prediction entries, power of 2, >= 2
  parameter int RAS_LAT = 2   // pop request to valid ras_branch_addr_i, >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid_i,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] if_inst_i,
  input  logic        pipe_flush_i,
  output logic        ras_push_o,
  output logic        ras_pop_o,
  output logic [31:0] ras_push_addr_o,
  input  logic [31:0] ras_branch_addr_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_is_link_i,
  input  logic        ex_is_return_i,
  input  logic [31:0] ex_target_i,
  output logic [31:0] corr_addr_o,
  output logic        corr_link_flag_o,
  output logic        corr_return_flag_o,
  output logic        ras_flush_o,
  output logic [31:0] redirect_pc_o
`ifdef RAS_CTRL_STAT_EN
  ,
  output logic [31:0] stat_ret_o,
  output logic [31:0] stat_miss_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // ---------------- predecode ----------------
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic       is_jal, is_jalr, is_jr, rs_ra;
  logic       push_raw, pop_raw, fe_ok;
  logic       unused_inst;

  assign op          = if_inst_i[31:26];
  assign funct       = if_inst_i[5:0];
  assign rs          = if_inst_i[25:21];
  assign unused_inst = ^if_inst_i[20:6];

  assign is_jal   = (op == 6'b000011);
  assign is_jalr  = (op == 6'b000000) && (funct == 6'b001001);
  assign is_jr    = (op == 6'b000000) && (funct == 6'b001000);
  assign rs_ra    = (rs == 5'd31);
  assign push_raw = is_jal || is_jalr;
  assign pop_raw  = (is_jr || is_jalr) && rs_ra;

  // Front-end requests are muted in reset, while the RAS is being flushed and
  // on an external pipeline flush (the fetched instruction is being killed).
  logic full, empty;
  assign fe_ok = rst && if_valid_i && !ras_flush_o && !pipe_flush_i;

  assign ras_push_o      = fe_ok && push_raw;
  // A full tracker cannot record the prediction, so the pop is not issued.
  assign ras_pop_o       = fe_ok && pop_raw && !full;
  assign ras_push_addr_o = ras_push_o ? (if_pc_i + 32'd8) : 32'd0;

  // ---------------- in-flight target FIFO ----------------
  logic [DEPTH-1:0][31:0]     tgt;
  logic [DEPTH-1:0]           tgt_vld;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic [RAS_LAT-1:0]         fill_vld;
  logic [RAS_LAT-1:0][AW-1:0] fill_idx;
  logic                       chk, deq, head_hit, miss, clr;
  logic                       miss_d1;
  logic [31:0]                miss_tgt_d1;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Head must have its RAS target landed already; a fill arriving this very
  // cycle is not visible yet and so counts as a mispredict.
  assign chk      = ex_valid_i && ex_is_return_i;
  assign head_hit = !empty && tgt_vld[rd_ptr] && (tgt[rd_ptr] == ex_target_i);
  assign miss     = chk && !head_hit;
  assign deq      = chk && !empty;

  // Clearing on miss_d1 makes the tracker empty during the ras_flush_o cycle.
  assign clr = pipe_flush_i || miss_d1;

  // Allocation on pop, RAS-latency fill line, target landing and head dequeue.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tgt_vld  <= '0;
      fill_vld <= '0;
    end else begin
      fill_vld[0] <= ras_pop_o;
      fill_idx[0] <= wr_ptr;
      for (int i = 1; i < RAS_LAT; i++) begin
        fill_vld[i] <= fill_vld[i-1];
        fill_idx[i] <= fill_idx[i-1];
      end
      if (fill_vld[RAS_LAT-1]) begin
        tgt[fill_idx[RAS_LAT-1]]     <= ras_branch_addr_i;
        tgt_vld[fill_idx[RAS_LAT-1]] <= 1'b1;
      end
      // Allocation after landing so a freshly reused slot starts invalid.
      if (ras_pop_o) begin
        tgt_vld[wr_ptr] <= 1'b0;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({ras_pop_o, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- correction bus and flush ----------------
  // Correction pulses one cycle after resolution; flush follows one cycle
  // later so the RAS already holds the correction while it is flushed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      corr_addr_o        <= '0;
      corr_link_flag_o   <= 1'b0;
      corr_return_flag_o <= 1'b0;
      miss_d1            <= 1'b0;
      miss_tgt_d1        <= '0;
      ras_flush_o        <= 1'b0;
      redirect_pc_o      <= '0;
    end else begin
      corr_link_flag_o   <= ex_valid_i && ex_is_link_i;
      corr_return_flag_o <= ex_valid_i && ex_is_return_i;
      corr_addr_o        <= (ex_valid_i && (ex_is_link_i || ex_is_return_i)) ? ex_pc_i : 32'd0;
      miss_d1            <= miss;
      miss_tgt_d1        <= ex_target_i;
      ras_flush_o        <= miss_d1;
      redirect_pc_o      <= miss_d1 ? miss_tgt_d1 : 32'd0;
    end
  end

`ifdef RAS_CTRL_STAT_EN
  // Saturating return-check and mispredict counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_ret_o  <= '0;
      stat_miss_o <= '0;
    end else begin
      if (chk && (stat_ret_o != 32'hFFFF_FFFF))  stat_ret_o  <= stat_ret_o + 32'd1;
      if (miss && (stat_miss_o != 32'hFFFF_FFFF)) stat_miss_o <= stat_miss_o + 32'd1;
    end
  end
`endif

endmodule
